seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Downstream consumer of stop_watch: takes its six BCD digit outputs (hr_h..sec_l) and time-multiplexes them onto one 8-bit seven-segment bus with six digit enables.
- Snapshots all six digits once per scan frame, so a digit rollover mid-frame never shows a mixed time.
- Provides leading-zero blanking, fixed separator dots and a dash for invalid BCD codes.

Parameters:
SCAN_DIV, 50000, Clk cycles each digit stays lit; legal range 2 or more.
SEG_ACT_LOW, 0, 1 = seg outputs are active-low (every bit inverted, including dp).
AN_ACT_LOW, 0, 1 = an outputs are active-low.

Ports:
Clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
hr_h  input  4  hours tens, BCD
hr_l  input  4  hours units, BCD
min_h  input  4  minutes tens, BCD
min_l  input  4  minutes units, BCD
sec_h  input  4  seconds tens, BCD
sec_l  input  4  seconds units, BCD
blank_lz  input  1  leading-zero blanking enable; level-sensitive, not snapshotted
seg  output  8  segments {dp,g,f,e,d,c,b,a}, registered
an  output  6  one-hot digit enable, bit0 = rightmost digit, registered
frame_tick  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- One clock (Clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - prescaler = 0, digit index = 0, all shadow digits = 0, load_pending = 1.
  - seg = all segments off, an = all digits off; "off" follows the polarity parameters.
  - frame_tick = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap cycle, index advances 0->1->...->5->0.
- Index-to-digit map: 0 = sec_l, 1 = sec_h, 2 = min_l, 3 = min_h, 4 = hr_l, 5 = hr_h.
- Snapshot:
  - All six shadow registers load together when load_pending = 1, or when prescaler = SCAN_DIV-1 and index = 5.
  - load_pending clears after the first load.
  - frame_tick = 1 in the cycle after each load, i.e. the first cycle that displays the new frame.
  - The first load happens on the first Clk edge after reset release, so frame 0 shows live inputs.
- Output path:
  - seg and an are registered from the current index and shadow values.
  - Latency is one cycle: when the index changes at edge N, the outputs change at edge N+1.
  - Each digit stays lit for exactly SCAN_DIV cycles.
- Decode (logical, active-high, dp excluded):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Codes 10..15 decode to dash, 40.
- Separator dots: dp (bit7) = 1 on index 2 (min_l) and index 4 (hr_l) when that digit is not blanked.
- Leading-zero blanking, applied only when blank_lz = 1:
  - hr_h blanks if it is 0.
  - Each lower digit down to min_l blanks if it is 0 and every digit above it is blanked.
  - sec_h and sec_l never blank.
  - A blanked slot drives seg off and an off for its full SCAN_DIV window. The scan timing does not change.
  - Invalid codes count as non-zero.
- Polarity: SEG_ACT_LOW and AN_ACT_LOW invert the final registered values only. Internal logic is always active-high.
- Boundary and corner cases:
  - An input change mid-frame has no visible effect until the next frame_tick.
  - blank_lz is sampled every cycle, so toggling it mid-frame affects the next displayed digit.
  - An asynchronous reset mid-scan forces reset values immediately, without waiting for a Clk edge.
- Sizing: a compliant implementation is about 150-250 RTL lines.

Test Plan:
- Reset: SCAN_DIV = 4, both polarity params 0; assert rst_n = 0 mid-digit between Clk edges -> an = 00, seg = 00, frame_tick = 0 immediately; after release, frame_tick pulses exactly once, 2 edges later.
- Normal scan, 12:34:56, blank_lz = 0:
  - an steps 01, 02, 04, 08, 10, 20, each held 4 cycles.
  - seg in order 7D, 6D, E6, 4F, DB, 06.
  - frame_tick repeats every 24 cycles.
- Tear-free snapshot: display 12:34:56, then change sec_l to 7 at the start of index 3 -> remainder of the frame unchanged; after the next frame_tick, index 0 shows seg = 07.
- Blanking, 00:00:07, blank_lz = 1 -> indices 5..2 drive an = 00 and seg = 00; index 1 shows an = 02, seg = 3F; index 0 shows an = 01, seg = 07.
- Blanking, 00:10:07, blank_lz = 1 -> min_h shows 06, min_l shows BF (dp on), hours blanked.
- Invalid code and polarity: sec_l = C -> seg = 40; same case with SEG_ACT_LOW = 1 and AN_ACT_LOW = 1 -> seg = BF, an = 3E at index 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// Six-digit multiplexed seven-segment driver for the stop_watch BCD outputs.
// Digits are snapshotted once per scan frame so a mid-frame rollover never tears.
module seg_scan_display #(
    parameter int SCAN_DIV    = 50000,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit AN_ACT_LOW  = 1'b0
) (
    input  logic       Clk,
    input  logic       rst_n,
    input  logic [3:0] hr_h,
    input  logic [3:0] hr_l,
    input  logic [3:0] min_h,
    input  logic [3:0] min_l,
    input  logic [3:0] sec_h,
    input  logic [3:0] sec_l,
    input  logic       blank_lz,
    output logic [7:0] seg,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [3:0]    r_sh [6];
    logic          r_load_pending;
    logic          r_load_q;

    logic          w_wrap;
    logic          w_load;
    logic [3:0]    w_digit;
    logic          w_blank_cur;
    logic [5:0]    w_blank;
    logic [6:0]    w_dec;
    logic          w_dp;
    logic [7:0]    w_seg_next;
    logic [5:0]    w_an_next;

    assign w_wrap = (r_presc == PW'(SCAN_DIV - 1));
    assign w_load = r_load_pending | (w_wrap && (r_idx == 3'd5));

    // Blanking cascades downward from hr_h and stops at min_l.
    assign w_blank[5] = blank_lz && (r_sh[5] == 4'd0);
    assign w_blank[4] = w_blank[5] && (r_sh[4] == 4'd0);
    assign w_blank[3] = w_blank[4] && (r_sh[3] == 4'd0);
    assign w_blank[2] = w_blank[3] && (r_sh[2] == 4'd0);
    assign w_blank[1] = 1'b0;
    assign w_blank[0] = 1'b0;

    always_comb begin
        w_digit     = 4'd0;
        w_blank_cur = 1'b0;
        w_dp        = 1'b0;
        case (r_idx)
            3'd0: begin w_digit = r_sh[0]; w_blank_cur = w_blank[0]; end
            3'd1: begin w_digit = r_sh[1]; w_blank_cur = w_blank[1]; end
            3'd2: begin w_digit = r_sh[2]; w_blank_cur = w_blank[2]; w_dp = 1'b1; end
            3'd3: begin w_digit = r_sh[3]; w_blank_cur = w_blank[3]; end
            3'd4: begin w_digit = r_sh[4]; w_blank_cur = w_blank[4]; w_dp = 1'b1; end
            3'd5: begin w_digit = r_sh[5]; w_blank_cur = w_blank[5]; end
            default: ;
        endcase
    end

    always_comb begin
        w_dec = 7'h40;
        case (w_digit)
            4'd0: w_dec = 7'h3F;
            4'd1: w_dec = 7'h06;
            4'd2: w_dec = 7'h5B;
            4'd3: w_dec = 7'h4F;
            4'd4: w_dec = 7'h66;
            4'd5: w_dec = 7'h6D;
            4'd6: w_dec = 7'h7D;
            4'd7: w_dec = 7'h07;
            4'd8: w_dec = 7'h7F;
            4'd9: w_dec = 7'h6F;
            default: w_dec = 7'h40;
        endcase
    end

    always_comb begin
        w_seg_next = 8'h00;
        w_an_next  = 6'h00;
        if (!w_blank_cur) begin
            w_seg_next = {w_dp, w_dec};
            w_an_next  = 6'b000001 << r_idx;
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) r_sh[i] <= 4'd0;
            r_load_pending <= 1'b1;
        end else if (w_load) begin
            r_sh[0]        <= sec_l;
            r_sh[1]        <= sec_h;
            r_sh[2]        <= min_l;
            r_sh[3]        <= min_h;
            r_sh[4]        <= hr_l;
            r_sh[5]        <= hr_h;
            r_load_pending <= 1'b0;
        end
    end

    // frame_tick is delayed twice so it coincides with the first displayed cycle of the new frame.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_q   <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= {8{SEG_ACT_LOW}};
            an         <= {6{AN_ACT_LOW}};
        end else begin
            r_load_q   <= w_load;
            frame_tick <= r_load_q;
            seg        <= w_seg_next ^ {8{SEG_ACT_LOW}};
            an         <= w_an_next ^ {6{AN_ACT_LOW}};
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: two instances (active-high and active-low) share stimulus;
// a frame-level reference model feeds an expected queue drained by a monitor.
module tb_seg_scan_display;

  localparam int SD = 4;
  localparam int W  = 15;  // {frame_tick, an[5:0], seg[7:0]}

  logic       Clk = 1'b0;
  logic       rst_n;
  logic [3:0] hr_h, hr_l, min_h, min_l, sec_h, sec_l;
  logic       blank_lz;
  logic [7:0] seg_a, seg_b;
  logic [5:0] an_a, an_b;
  logic       tick_a, tick_b;

  logic [W-1:0] exp_q[$];
  int           edge_q[$];
  int           errors = 0;
  int           checks = 0;
  int           n = 0;
  logic [3:0]   snap [6];
  logic [7:0]   dec_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

  seg_scan_display #(.SCAN_DIV(SD), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) dut_a (
    .Clk(Clk), .rst_n(rst_n), .hr_h(hr_h), .hr_l(hr_l), .min_h(min_h), .min_l(min_l),
    .sec_h(sec_h), .sec_l(sec_l), .blank_lz(blank_lz),
    .seg(seg_a), .an(an_a), .frame_tick(tick_a)
  );

  seg_scan_display #(.SCAN_DIV(SD), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut_b (
    .Clk(Clk), .rst_n(rst_n), .hr_h(hr_h), .hr_l(hr_l), .min_h(min_h), .min_l(min_l),
    .sec_h(sec_h), .sec_l(sec_l), .blank_lz(blank_lz),
    .seg(seg_b), .an(an_b), .frame_tick(tick_b)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end (got running, need finished)");
    $fatal(1, "timeout");
  end

  // Reference: what one slot of a frame looks like, from the snapshotted digits.
  function automatic logic [13:0] disp(input int idx, input logic lz);
    logic       blank;
    logic [7:0] s;
    logic [5:0] a;
    blank = lz && (idx >= 2);
    for (int j = idx; j <= 5; j++) if (snap[j] != 4'd0) blank = 1'b0;
    if (blank) return 14'h0;
    s = dec_tbl[snap[idx]];
    if (idx == 2 || idx == 4) s[7] = 1'b1;
    a = 6'd0;
    a[idx] = 1'b1;
    return {a, s};
  endfunction

  // driver tasks
  task automatic set_time(input logic [3:0] d5, d4, d3, d2, d1, d0);
    hr_h = d5; hr_l = d4; min_h = d3; min_l = d2; sec_h = d1; sec_l = d0;
  endtask

  task automatic run(input int cycles);
    logic          t;
    logic [W-1:0]  e;
    for (int k = 0; k < cycles; k++) begin
      n++;
      t = (n == 2) || (n > 6 * SD && ((n - 1) % (6 * SD)) == 0);
      e = {t, disp(((n - 1) / SD) % 6, blank_lz)};
      exp_q.push_back(e);
      edge_q.push_back(n);
      if (n == 1 || (n % (6 * SD)) == 0) begin
        snap[0] = sec_l; snap[1] = sec_h; snap[2] = min_l;
        snap[3] = min_h; snap[4] = hr_l;  snap[5] = hr_h;
      end
      @(negedge Clk);
    end
  endtask

  task automatic restart_model();
    n = 0;
    for (int i = 0; i < 6; i++) snap[i] = 4'd0;
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({tick_a, an_a, seg_a} !== 15'h0) begin
      errors++;
      $display("FAIL %s act_high: got tick=%0b an=%h seg=%h, need 0/00/00", name, tick_a, an_a, seg_a);
    end
    checks++;
    if ({tick_b, an_b, seg_b} !== {1'b0, 6'h3F, 8'hFF}) begin
      errors++;
      $display("FAIL %s act_low: got tick=%0b an=%h seg=%h, need 0/3f/ff", name, tick_b, an_b, seg_b);
    end
  endtask

  function automatic logic [3:0] rand_digit();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 4'd0;
    if (r < 8) return 4'($urandom_range(1, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    int           ed;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ed = edge_q.pop_front();
        checks++;
        if ({tick_a, an_a, seg_a} !== e) begin
          errors++;
          $display("FAIL slot_act_high edge %0d: got tick=%0b an=%h seg=%h, need tick=%0b an=%h seg=%h",
                   ed, tick_a, an_a, seg_a, e[14], e[13:8], e[7:0]);
        end
        checks++;
        if ({tick_b, ~an_b, ~seg_b} !== e) begin
          errors++;
          $display("FAIL slot_act_low edge %0d: got tick=%0b an=%h seg=%h, need tick=%0b an=%h seg=%h",
                   ed, tick_b, an_b, seg_b, e[14], ~e[13:8], ~e[7:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    blank_lz = 1'b0;
    set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    restart_model();
    repeat (2) @(negedge Clk);
    check_reset("reset_hold");

    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    rst_n = 1'b1;
    run(72);

    // sec_l changes as index 3 starts; shows only after the next snapshot
    run(12);
    sec_l = 4'd7;
    run(36);

    blank_lz = 1'b1;
    set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
    run(48);
    set_time(4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd7);
    run(48);

    blank_lz = 1'b0;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hC);
    run(48);

    // blank_lz toggled mid-frame acts on the next displayed digit
    blank_lz = 1'b1;
    set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
    run(10);
    blank_lz = 1'b0;
    run(6);
    blank_lz = 1'b1;
    run(32);

    for (int f = 0; f < 24; f++) begin
      set_time(rand_digit(), rand_digit(), rand_digit(), rand_digit(), rand_digit(), rand_digit());
      blank_lz = 1'($urandom_range(0, 1));
      run($urandom_range(1, 30));
      if ($urandom_range(0, 3) == 0) blank_lz = ~blank_lz;
      run($urandom_range(1, 20));
    end

    // asynchronous reset asserted between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    @(negedge Clk);
    check_reset("reset_async_hold");
    restart_model();
    blank_lz = 1'b0;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    rst_n = 1'b1;
    run(50);

    @(posedge Clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, need 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
